// File: rtl/ex_mem_cc_stage_if.sv
// EX->MEM stage bundle: ALU/EX-side inputs into the stage and the registered MEM-side / icc
// outputs coming back out.
//   master : EX side (drives ALU result, flags, opcode, control; observes stage outputs)
//   slave  : the ex_mem_cc_stage itself
interface ex_mem_cc_stage_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RDW = 5
);
  // EX-side inputs
  logic [DW-1:0]  alu_y;
  logic           alu_n;
  logic           alu_z;
  logic           alu_c;
  logic           alu_v;
  logic [5:0]     alu_op;
  logic           ex_valid;
  logic [RDW-1:0] ex_rd;
  logic           ex_wr_en;
  logic           br_eval;
  logic [3:0]     cond;
  logic           stall;
  logic           flush;
  // MEM-side / icc outputs
  logic [DW-1:0]  mem_y;
  logic [RDW-1:0] mem_rd;
  logic           mem_wr_en;
  logic           mem_valid;
  logic           icc_n;
  logic           icc_z;
  logic           icc_c;
  logic           icc_v;
  logic           ci_out;
  logic           br_taken;

  modport master (
    output alu_y, alu_n, alu_z, alu_c, alu_v, alu_op, ex_valid, ex_rd, ex_wr_en,
           br_eval, cond, stall, flush,
    input  mem_y, mem_rd, mem_wr_en, mem_valid, icc_n, icc_z, icc_c, icc_v, ci_out, br_taken
  );

  modport slave (
    input  alu_y, alu_n, alu_z, alu_c, alu_v, alu_op, ex_valid, ex_rd, ex_wr_en,
           br_eval, cond, stall, flush,
    output mem_y, mem_rd, mem_wr_en, mem_valid, icc_n, icc_z, icc_c, icc_v, ci_out, br_taken
  );
endinterface

// File: rtl/ex_mem_cc_stage.sv
// EX->MEM pipeline register plus integer condition-code register (icc).
// Latches the ALU result and destination for MEM, updates NZCV on cc-modifying opcodes,
// feeds the registered C back to the ALU carry-in, and registers the branch decision
// evaluated against the icc as it stood before the current edge.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of ex_mem_cc_stage_if (EX inputs, MEM/icc outputs)
module ex_mem_cc_stage #(
  parameter int unsigned DW        = 32,
  parameter int unsigned RDW       = 5,
  parameter bit          LOGIC_CV0 = 1'b1
) (
  input logic              clk,
  input logic              reset,
  ex_mem_cc_stage_if.slave bus
);

  logic [DW-1:0]  y_q, y_d;
  logic [RDW-1:0] rd_q, rd_d;
  logic           wr_en_q, wr_en_d;
  logic           valid_q, valid_d;
  logic [3:0]     icc_q, icc_d;  // {N, Z, C, V}
  logic           br_q, br_d;

  logic           is_arith, is_logic;
  logic           br_base, br_res;

  // Opcode classification for icc writes.
  always_comb begin
    is_arith = 1'b0;
    is_logic = 1'b0;
    case (bus.alu_op)
      6'b010000, 6'b011000, 6'b010100, 6'b011100: is_arith = 1'b1;
      6'b010001, 6'b010010, 6'b010011,
      6'b010101, 6'b010110, 6'b010111:            is_logic = 1'b1;
      default: ;
    endcase
  end

  // cond[3] inverts the base test selected by cond[2:0] (BN/BA, BE/BNE, ...).
  always_comb begin
    br_base = 1'b0;
    case (bus.cond[2:0])
      3'd0: br_base = 1'b0;
      3'd1: br_base = icc_q[2];
      3'd2: br_base = icc_q[2] | (icc_q[3] ^ icc_q[0]);
      3'd3: br_base = icc_q[3] ^ icc_q[0];
      3'd4: br_base = icc_q[1] | icc_q[2];
      3'd5: br_base = icc_q[1];
      3'd6: br_base = icc_q[3];
      3'd7: br_base = icc_q[0];
      default: br_base = 1'b0;
    endcase
    br_res = br_base ^ bus.cond[3];
  end

  always_comb begin
    y_d     = y_q;
    rd_d    = rd_q;
    wr_en_d = wr_en_q;
    valid_d = valid_q;
    icc_d   = icc_q;
    br_d    = br_q;
    if (bus.flush) begin
      // Squash: result/destination are don't-care once invalid, so they simply hold.
      valid_d = 1'b0;
      wr_en_d = 1'b0;
      br_d    = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.ex_valid;
      y_d     = bus.alu_y;
      rd_d    = bus.ex_rd;
      wr_en_d = bus.ex_valid & bus.ex_wr_en;
      br_d    = bus.ex_valid & bus.br_eval & br_res;
      if (bus.ex_valid && is_arith) begin
        icc_d = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
      end else if (bus.ex_valid && is_logic) begin
        icc_d = {bus.alu_n, bus.alu_z, (LOGIC_CV0 ? 2'b00 : {bus.alu_c, bus.alu_v})};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q     <= '0;
      rd_q    <= '0;
      wr_en_q <= 1'b0;
      valid_q <= 1'b0;
      icc_q   <= 4'b0000;
      br_q    <= 1'b0;
    end else begin
      y_q     <= y_d;
      rd_q    <= rd_d;
      wr_en_q <= wr_en_d;
      valid_q <= valid_d;
      icc_q   <= icc_d;
      br_q    <= br_d;
    end
  end

  assign bus.mem_y     = y_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_valid = valid_q;
  assign bus.icc_n     = icc_q[3];
  assign bus.icc_z     = icc_q[2];
  assign bus.icc_c     = icc_q[1];
  assign bus.icc_v     = icc_q[0];
  // Registered C goes straight back as carry-in; addx/subx see it the cycle after a cc op.
  assign bus.ci_out    = icc_q[1];
  assign bus.br_taken  = br_q;

endmodule

// File: tb/tb_ex_mem_cc_stage.sv
// Self-checking bench for ex_mem_cc_stage: directed scenarios plus a randomized run,
// all checked against a behavioural model of the stage kept here.
module tb_ex_mem_cc_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  ex_mem_cc_stage_if #(.DW(32), .RDW(5)) bus ();

  ex_mem_cc_stage #(.DW(32), .RDW(5), .LOGIC_CV0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_y;
  logic [4:0]  m_rd;
  logic        m_wr;
  logic        m_val;
  logic [3:0]  m_icc;  // {N, Z, C, V}
  logic        m_br;

  function automatic logic branch_ref(input logic [3:0] c, input logic [3:0] icc);
    logic n, z, cy, v;
    {n, z, cy, v} = icc;
    case (c)
      4'b0000: return 1'b0;
      4'b1000: return 1'b1;
      4'b0001: return z;
      4'b1001: return !z;
      4'b0010: return z || (n != v);
      4'b1010: return !(z || (n != v));
      4'b0011: return n != v;
      4'b1011: return n == v;
      4'b0100: return cy || z;
      4'b1100: return !(cy || z);
      4'b0101: return cy;
      4'b1101: return !cy;
      4'b0110: return n;
      4'b1110: return !n;
      4'b0111: return v;
      default: return !v;
    endcase
  endfunction

  function automatic logic [44:0] model_vec();
    return {m_y, m_rd, m_wr, m_val, m_icc, m_icc[1], m_br};
  endfunction

  function automatic logic [44:0] dut_vec();
    return {bus.mem_y, bus.mem_rd, bus.mem_wr_en, bus.mem_valid, bus.icc_n, bus.icc_z,
            bus.icc_c, bus.icc_v, bus.ci_out, bus.br_taken};
  endfunction

  task automatic drive(input logic v, input logic wr, input logic [4:0] rd,
                       input logic [5:0] op, input logic [31:0] y, input logic [3:0] nzcv,
                       input logic be, input logic [3:0] c, input logic st, input logic fl);
    bus.ex_valid = v;
    bus.ex_wr_en = wr;
    bus.ex_rd    = rd;
    bus.alu_op   = op;
    bus.alu_y    = y;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
    bus.br_eval  = be;
    bus.cond     = c;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic drive_random();
    drive(1'(($urandom)), 1'(($urandom)), 5'($urandom), 6'($urandom), $urandom, 4'($urandom),
          1'(($urandom)), 4'($urandom), 1'(($urandom)), 1'(($urandom)));
  endtask

  // Advance the model by one edge using the inputs currently driven, then wait for the edge.
  task automatic tick();
    logic [5:0] op;
    op = bus.alu_op;
    if (reset) begin
      m_y = '0; m_rd = '0; m_wr = 0; m_val = 0; m_icc = '0; m_br = 0;
    end else if (bus.flush) begin
      m_val = 0; m_wr = 0; m_br = 0;
    end else if (!bus.stall) begin
      m_br = bus.ex_valid && bus.br_eval && branch_ref(bus.cond, m_icc);
      if (bus.ex_valid) begin
        if (op inside {6'b010000, 6'b011000, 6'b010100, 6'b011100})
          m_icc = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        else if (op inside {6'b010001, 6'b010010, 6'b010011, 6'b010101, 6'b010110, 6'b010111})
          m_icc = {bus.alu_n, bus.alu_z, 2'b00};
      end
      m_val = bus.ex_valid;
      m_y   = bus.alu_y;
      m_rd  = bus.ex_rd;
      m_wr  = bus.ex_valid && bus.ex_wr_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
    end
    n_cmp++;
    if (dut_vec() !== 45'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h want %h", dut_vec(), 45'd0);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (dut_vec() !== 45'd0) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", dut_vec(), 45'd0);
    end
  endtask

  task automatic test_overflow();
    drive(1, 1, 5'd3, 6'b010000, 32'h8000_0000, 4'b1001, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if ({bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v} !== 4'b1001) begin
      n_err++;
      $display("FAIL overflow_icc: got %b want %b",
               {bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v}, 4'b1001);
    end
    n_cmp++;
    if (bus.mem_y !== 32'h8000_0000 || bus.mem_rd !== 5'd3 || bus.mem_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_data: got y=%h rd=%0d wr=%b want y=80000000 rd=3 wr=1",
               bus.mem_y, bus.mem_rd, bus.mem_wr_en);
    end
  endtask

  task automatic test_no_cc();
    drive(1, 0, 5'd1, 6'b010000, 32'h0, 4'b0100, 0, 0, 0, 0);
    tick();
    drive(1, 1, 5'd9, 6'b000000, 32'h1234_5678, 4'b1010, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if ({bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v} !== 4'b0100 || bus.mem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL no_cc: got icc=%b valid=%b want icc=0100 valid=1",
               {bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v}, bus.mem_valid);
    end
  endtask

  task automatic test_stall_flush();
    logic [44:0] snap, exp;
    snap = model_vec();
    for (int i = 0; i < 3; i++) begin
      drive_random();
      bus.stall = 1'b1;
      bus.flush = 1'b0;
      tick();
      n_cmp++;
      if (dut_vec() !== snap) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_vec(), snap);
      end
    end
    drive_random();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    exp = snap;
    exp[7] = 1'b0;  // wr_en
    exp[6] = 1'b0;  // valid
    exp[0] = 1'b0;  // br_taken
    n_cmp++;
    if (dut_vec() !== exp) begin
      n_err++;
      $display("FAIL stall_flush: got %h want %h", dut_vec(), exp);
    end
  endtask

  task automatic test_branch();
    logic [3:0] conds [4];
    logic       exps  [4];
    conds = '{4'b1010, 4'b0001, 4'b1000, 4'b0000};
    exps  = '{1'b1, 1'b0, 1'b1, 1'b0};
    // subcc 8-7 = 1: NZCV = 0000
    drive(1, 1, 5'd4, 6'b010100, 32'd1, 4'b0000, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 5'd0, 6'b000000, 32'd0, 4'b1111, 1, conds[i], 0, 0);
      tick();
      n_cmp++;
      if (bus.br_taken !== exps[i]) begin
        n_err++;
        $display("FAIL branch_cond_%b: got %b want %b", conds[i], bus.br_taken, exps[i]);
      end
    end
  endtask

  task automatic test_logic_cc();
    drive(1, 0, 5'd0, 6'b010000, 32'd0, 4'b0010, 0, 0, 0, 0);  // set C first
    tick();
    drive(1, 1, 5'd7, 6'b010001, 32'd0, 4'b0111, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if ({bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v} !== 4'b0100 || bus.ci_out !== 1'b0) begin
      n_err++;
      $display("FAIL logic_cc: got icc=%b ci=%b want icc=0100 ci=0",
               {bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v}, bus.ci_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 5'd2, 6'b010000, 32'h0000_0000, 4'b0110, 0, 0, 0, 0);  // addcc carry out
    tick();
    n_cmp++;
    if (bus.ci_out !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ci: got %b want 1", bus.ci_out);
    end
    drive(1, 1, 5'd3, 6'b011000, 32'h0000_0001, 4'b0000, 0, 0, 0, 0);  // addxcc
    tick();
    n_cmp++;
    if ({bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v} !== 4'b0000 || bus.mem_y !== 32'd1) begin
      n_err++;
      $display("FAIL b2b_second: got icc=%b y=%h want icc=0000 y=00000001",
               {bus.icc_n, bus.icc_z, bus.icc_c, bus.icc_v}, bus.mem_y);
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 0, 5'd0, 6'b010000, 32'd0, 4'b0100, 0, 0, 0, 0);  // Z=1
    tick();
    drive(1, 0, 5'd0, 6'b010000, 32'd5, 4'b0000, 1, 4'b0001, 0, 0);  // BE with cc update
    tick();
    n_cmp++;
    if (bus.br_taken !== 1'b1 || bus.icc_z !== 1'b0) begin
      n_err++;
      $display("FAIL same_cycle: got br=%b z=%b want br=1 z=0", bus.br_taken, bus.icc_z);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    ops = '{6'b010000, 6'b011000, 6'b010100, 6'b011100, 6'b010001, 6'b010010,
            6'b010011, 6'b010101, 6'b010110, 6'b010111, 6'b011111, 6'b000000};
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if ($urandom_range(0, 3) != 0) bus.alu_op = ops[$urandom_range(0, 11)];
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    m_y = '0; m_rd = '0; m_wr = 0; m_val = 0; m_icc = '0; m_br = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_overflow();
    test_no_cc();
    test_stall_flush();
    test_branch();
    test_logic_cc();
    test_back_to_back();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
